// File: rtl/async_merge_sink.sv
// Clock-domain sink for the 3-input asynchronous merge: synchronises drive, captures
// the bundled word into a show-ahead FIFO and returns a free pulse. Stats: ASYNC_MERGE_SINK_STATS_EN.
module async_merge_sink #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int FREE_PULSE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_drive,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_free,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [15:0]                o_words,
  output logic [15:0]                o_stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = $clog2(FREE_PULSE_CYCLES + 1);
  localparam logic [FC_W-1:0] FREE_LOAD = FC_W'(FREE_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, ACK, WAIT_LOW} state_t;

  state_t                  state, state_nxt;
  logic [FC_W-1:0]         free_cnt, free_cnt_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    drv_s, drv_q, drv_edge;
  logic                    push, pop, can_push;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // i_drive is asynchronous; i_data is held stable by upstream so it needs no synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      drv_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes this shift chain a chain rather than a single wire.
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_drive};
      drv_q  <= drv_s;
    end
  end

  assign drv_s    = sync_q[SYNC_STAGES-1];
  assign drv_edge = drv_s & ~drv_q;
  assign o_valid  = (count != '0);
  assign pop      = o_valid & i_ready;
  assign can_push = (count < CNT_W'(DEPTH)) | pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      free_cnt <= '0;
    end else begin
      state    <= state_nxt;
      free_cnt <= free_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    free_cnt_nxt = free_cnt;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (drv_edge) begin
          if (can_push) begin
            push         = 1'b1;
            free_cnt_nxt = FREE_LOAD;
            state_nxt    = ACK;
          end else begin
            state_nxt    = HOLD;
          end
        end
      end
      HOLD: begin
        // A fall of drv_s here is ignored: the word is still owed a slot.
        if (can_push) begin
          push         = 1'b1;
          free_cnt_nxt = FREE_LOAD;
          state_nxt    = ACK;
        end
      end
      ACK: begin
        if (free_cnt == '0) state_nxt = drv_s ? WAIT_LOW : IDLE;
        else                free_cnt_nxt = free_cnt - 1'b1;
      end
      WAIT_LOW: begin
        if (!drv_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_free = (state == ACK);

  // NOTE: the storage array is deliberately not reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  assign o_count = count;

`ifdef ASYNC_MERGE_SINK_STATS_EN
  logic [15:0] words_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (push)          words_q <= words_q + 16'd1;
      if (state == HOLD) stall_q <= stall_q + 16'd1;
    end
  end

  assign o_words        = words_q;
  assign o_stall_cycles = stall_q;
`else
  assign o_words        = '0;
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_async_merge_sink.sv
// Self-checking bench for async_merge_sink: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_async_merge_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int FPC   = 2;
`ifdef ASYNC_MERGE_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, rst, i_drive, i_ready;
  logic [DW-1:0] i_data, o_data;
  logic          o_free, o_valid;
  logic [2:0]    o_count;
  logic [15:0]   o_words, o_stall_cycles;

  async_merge_sink #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .FREE_PULSE_CYCLES(FPC)
  ) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_count(o_count),
    .o_words(o_words), .o_stall_cycles(o_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a request becomes visible SS edges after i_drive is sampled,
  // is accepted when there is room (counting a same-edge pop), then free is owed
  // for FPC cycles and a new request needs the request line seen low first.
  logic [DW-1:0] mq[$];
  logic [SS:0]   seen;
  int            free_left;
  bit            pending, need_low;
  int            m_words, m_stalls;

  always @(posedge clk) begin : model
    bit m_pop, m_room, now_hi, prev_hi;
    if (rst) begin
      mq.delete();
      seen      = '0;
      free_left = 0;
      pending   = 1'b0;
      need_low  = 1'b0;
      m_words   = 0;
      m_stalls  = 0;
    end else begin
      now_hi  = seen[SS-1];
      prev_hi = seen[SS];
      m_pop   = (mq.size() != 0) && i_ready;
      m_room  = (mq.size() < DEPTH) || m_pop;
      if (pending) m_stalls = (m_stalls + 1) % 65536;
      if (m_pop) void'(mq.pop_front());
      if (free_left > 0) begin
        free_left--;
        if (free_left == 0 && now_hi) need_low = 1'b1;
      end else if (need_low) begin
        if (!now_hi) need_low = 1'b0;
      end else begin
        if (now_hi && !prev_hi) pending = 1'b1;
        if (pending && m_room) begin
          mq.push_back(i_data);
          pending   = 1'b0;
          free_left = FPC;
          m_words   = (m_words + 1) % 65536;
        end
      end
      seen = {seen[SS-1:0], i_drive};
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_free",  o_free,  free_left > 0);
      check("cyc_valid", o_valid, mq.size() != 0);
      check("cyc_count", o_count, mq.size());
      check("cyc_data",  o_data,  (mq.size() != 0) ? mq[0] : '0);
      check("cyc_words", o_words, STATS ? m_words : 0);
      check("cyc_stall", o_stall_cycles, STATS ? m_stalls : 0);
    end
  end

  bit            mon_en = 1'b0;
  int            max_cnt;
  logic [DW-1:0] got[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(o_count) > max_cnt) max_cnt = o_count;
      if (o_valid && i_ready) got.push_back(o_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input logic [DW-1:0] w, input int hold);
    i_data  = w;
    i_drive = 1'b1;
    tick(hold);
    i_drive = 1'b0;
  endtask

  task automatic wait_free_done(input string name);
    bit seen_free = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (o_free) seen_free = 1'b1;
      else if (seen_free) break;
      @(negedge clk);
    end
    check(name, seen_free && !o_free, 1'b1);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    raise(w, 3);
    wait_free_done("send_free_pulse");
  endtask

  initial begin
    logic [5:0] fr;
    int         rises;
    bit         prev;

    rst = 1'b1; i_drive = 1'b0; i_ready = 1'b0; i_data = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    tick(2);
    check("rst_free",  o_free,  0);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_data",  o_data,  0);
    check("rst_words", o_words, 0);
    check("rst_stall", o_stall_cycles, 0);
    rst = 1'b0;
    tick(1);

    // Single word: free high on cycles 2..3 after edge 0.
    i_data = 32'hA5A5_0001; i_drive = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      fr[k] = o_free;
      if (k == 2) i_drive = 1'b0;
    end
    check("single_free_window", fr, 6'b001100);
    check("single_valid", o_valid, 1);
    check("single_data",  o_data,  32'hA5A5_0001);
    check("single_count", o_count, 1);
    i_ready = 1'b1; tick(1); i_ready = 1'b0;
    check("single_drained", o_count, 0);

    // Full to HOLD, from a fresh reset so the stats are easy to pin.
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    for (int w = 1; w <= 4; w++) send_word(DW'(w));
    check("full_count", o_count, 4);
    raise(32'h5, 3);
    tick(4);
    check("hold_no_free", o_free,  0);
    check("hold_count",   o_count, 4);
    check("hold_head",    o_data,  32'h1);
    i_ready = 1'b1; tick(1); i_ready = 1'b0;
    check("hold_swap_count", o_count, 4);
    check("hold_swap_free",  o_free,  1);
    check("hold_swap_head",  o_data,  32'h2);
    check("hold_words", o_words,        STATS ? 5 : 0);
    check("hold_stall", o_stall_cycles, STATS ? 5 : 0);
    wait_free_done("hold_free_pulse");
    i_ready = 1'b1; tick(4); i_ready = 1'b0;
    check("hold_drained", o_count, 0);

    // Wrap-around with a consumer that is always ready.
    i_ready = 1'b1; max_cnt = 0; got.delete();
    tick(1);
    mon_en = 1'b1;
    for (int w = 0; w < 10; w++) send_word(DW'(w));
    tick(2);
    mon_en = 1'b0;
    check("wrap_max_count", max_cnt, 1);
    check("wrap_num_words", got.size(), 10);
    for (int i = 0; i < got.size(); i++) check("wrap_order", got[i], DW'(i));
    i_ready = 1'b0;

    // Long drive: exactly one push and one free pulse.
    i_data = 32'hCAFE_0004; i_drive = 1'b1; rises = 0; prev = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (o_free && !prev) rises++;
      prev = o_free;
      if (k == 11) i_drive = 1'b0;
    end
    check("long_free_pulses", rises, 1);
    check("long_count", o_count, 1);
    check("long_data",  o_data,  32'hCAFE_0004);

    // Reset while in ACK with two words held.
    i_data = 32'h22; i_drive = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_free) break;
    end
    check("mid_in_ack",   o_free,  1);
    check("mid_count",    o_count, 2);
    rst = 1'b1; i_drive = 1'b0;
    tick(1);
    check("mid_rst_free",  o_free,  0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_data",  o_data,  0);
    check("mid_rst_words", o_words, 0);
    rst = 1'b0;
    tick(1);
    send_word(32'h33);
    check("post_rst_count", o_count, 1);
    check("post_rst_data",  o_data,  32'h33);
    check("post_rst_words", o_words, STATS ? 1 : 0);
    tick(2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
